// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core and host request ports plus the shared data-memory port.
interface dmem_arbiter_if #(parameter int AW = 8, parameter int DW = 8);
    logic          c_req, c_we, c_gnt, c_rvalid;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic          h_req, h_we, h_lock, h_gnt, h_rvalid;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata, h_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    modport master (
        output c_req, c_we, c_addr, c_wdata, h_req, h_we, h_lock, h_addr, h_wdata, mem_rdata,
        input  c_gnt, c_rvalid, c_rdata, h_gnt, h_rvalid, h_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  c_req, c_we, c_addr, c_wdata, h_req, h_we, h_lock, h_addr, h_wdata, mem_rdata,
        output c_gnt, c_rvalid, c_rdata, h_gnt, h_rvalid, h_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin core/host arbiter for one data memory with host burst lock.
// Define ARB_STATS_EN to add saturating 16-bit grant counters c_cnt_o/h_cnt_o.
module dmem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]   c_cnt_o,
    output logic [15:0]   h_cnt_o
`endif
);
    localparam logic CORE = 1'b0;
    localparam logic HOST = 1'b1;

    logic          owner_q, owner_d, lock_q, lock_d;
    logic          c_rd_q, h_rd_q, c_gnt, h_gnt;
    logic [DW-1:0] c_rdata_q, h_rdata_q, wdata_d;
    logic [AW-1:0] addr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q   <= HOST;
            lock_q    <= 1'b0;
            c_rd_q    <= 1'b0;
            h_rd_q    <= 1'b0;
            c_rdata_q <= '0;
            h_rdata_q <= '0;
        end else begin
            owner_q   <= owner_d;
            lock_q    <= lock_d;
            c_rd_q    <= c_gnt & ~bus.c_we;
            h_rd_q    <= h_gnt & ~bus.h_we;
            c_rdata_q <= c_rd_q ? bus.mem_rdata : c_rdata_q;
            h_rdata_q <= h_rd_q ? bus.mem_rdata : h_rdata_q;
        end
    end

    // Core loses a contended cycle only to a locked host or when it owned the last access.
    always_comb begin
        c_gnt   = ~reset & bus.c_req & ~(bus.h_req & (lock_q | (owner_q == CORE)));
        h_gnt   = ~reset & bus.h_req & ~c_gnt;
        owner_d = c_gnt ? CORE : h_gnt ? HOST : owner_q;
        lock_d  = bus.h_req & bus.h_lock & (h_gnt | lock_q);
    end

    always_comb begin
        addr_d        = c_gnt ? bus.c_addr : h_gnt ? bus.h_addr : '0;
        wdata_d       = c_gnt ? bus.c_wdata : h_gnt ? bus.h_wdata : '0;
        bus.c_gnt     = c_gnt;
        bus.h_gnt     = h_gnt;
        bus.mem_en    = c_gnt | h_gnt;
        bus.mem_we    = c_gnt ? bus.c_we : h_gnt & bus.h_we;
        bus.mem_addr  = addr_d;
        bus.mem_wdata = wdata_d;
        bus.c_rvalid  = c_rd_q & ~reset;
        bus.h_rvalid  = h_rd_q & ~reset;
        bus.c_rdata   = reset ? '0 : c_rd_q ? bus.mem_rdata : c_rdata_q;
        bus.h_rdata   = reset ? '0 : h_rd_q ? bus.mem_rdata : h_rdata_q;
    end

`ifdef ARB_STATS_EN
    logic [15:0] c_cnt_q, h_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            c_cnt_q <= '0;
            h_cnt_q <= '0;
        end else begin
            c_cnt_q <= c_cnt_q + 16'(c_gnt && (c_cnt_q != 16'hFFFF));
            h_cnt_q <= h_cnt_q + 16'(h_gnt && (h_cnt_q != 16'hFFFF));
        end
    end

    assign c_cnt_o = c_cnt_q;
    assign h_cnt_o = h_cnt_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus random traffic against a rule-level arbiter model.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(8), .DW(8)) bus ();
`ifdef ARB_STATS_EN
    logic [15:0] c_cnt, h_cnt;
`endif

    dmem_arbiter #(.AW(8), .DW(8)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef ARB_STATS_EN
        ,
        .c_cnt_o(c_cnt),
        .h_cnt_o(h_cnt)
`endif
    );

    // Memory environment: one-cycle read latency, random data when not reading.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : 8'($urandom);
    end

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit         last_host, locked, pc, ph, eg_c, eg_h;
    logic [7:0] pcd, phd, c_hold, h_hold;
    logic [7:0] ref_mem [256];
    int         cc, hc;
    logic       s_cg, s_hg, s_crv, s_hrv, s_me;
    logic [7:0] s_crd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (reset) begin
            eg_c = 0;
            eg_h = 0;
        end else if (bus.c_req && bus.h_req) begin
            eg_h = locked || !last_host;
            eg_c = !eg_h;
        end else begin
            eg_c = bus.c_req;
            eg_h = bus.h_req;
        end
        s_cg = bus.c_gnt; s_hg = bus.h_gnt; s_crv = bus.c_rvalid; s_hrv = bus.h_rvalid;
        s_me = bus.mem_en; s_crd = bus.c_rdata;
        chk("c_gnt", bus.c_gnt, eg_c);
        chk("h_gnt", bus.h_gnt, eg_h);
        chk("excl", bus.c_gnt & bus.h_gnt, 0);
        chk("mem_en_or", bus.mem_en, bus.c_gnt | bus.h_gnt);
        chk("mem_en", bus.mem_en, eg_c | eg_h);
        chk("mem_we", bus.mem_we, eg_c ? bus.c_we : eg_h ? bus.h_we : 1'b0);
        chk("mem_addr", bus.mem_addr, eg_c ? bus.c_addr : eg_h ? bus.h_addr : 8'h0);
        chk("mem_wdata", bus.mem_wdata, eg_c ? bus.c_wdata : eg_h ? bus.h_wdata : 8'h0);
        chk("c_rvalid", bus.c_rvalid, pc && !reset);
        chk("h_rvalid", bus.h_rvalid, ph && !reset);
        chk("c_rdata", bus.c_rdata, reset ? 8'h0 : pc ? pcd : c_hold);
        chk("h_rdata", bus.h_rdata, reset ? 8'h0 : ph ? phd : h_hold);
`ifdef ARB_STATS_EN
        chk("c_cnt", c_cnt, cc);
        chk("h_cnt", h_cnt, hc);
`endif
        @(posedge clk);
        if (reset) begin
            last_host = 1; locked = 0; pc = 0; ph = 0; c_hold = 0; h_hold = 0; cc = 0; hc = 0;
        end else begin
            if (pc) c_hold = pcd;
            if (ph) h_hold = phd;
            pc = eg_c && !bus.c_we;
            ph = eg_h && !bus.h_we;
            if (eg_c) begin
                pcd = ref_mem[bus.c_addr];
                if (bus.c_we) ref_mem[bus.c_addr] = bus.c_wdata;
                last_host = 0;
                if (cc < 65535) cc++;
            end
            if (eg_h) begin
                phd = ref_mem[bus.h_addr];
                if (bus.h_we) ref_mem[bus.h_addr] = bus.h_wdata;
                last_host = 1;
                if (hc < 65535) hc++;
            end
            if (eg_h && bus.h_lock) locked = 1;
            else if (!bus.h_lock || !bus.h_req) locked = 0;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h0;
            ref_mem[i] = 8'h0;
        end
        {bus.c_req, bus.c_we, bus.h_req, bus.h_we, bus.h_lock} = '0;
        {bus.c_addr, bus.c_wdata, bus.h_addr, bus.h_wdata} = '0;
        reset = 1;
        bus.c_req = 1;
        bus.h_req = 1;
        step();
        chk("rst_mem_en", s_me, 0);
        step();
        // Contended reads after reset: core first, then alternate
        reset = 0;
        bus.c_addr = 8'd1;
        bus.h_addr = 8'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("alt_c", s_cg, (i % 2) == 0);
            chk("alt_h", s_hg, (i % 2) == 1);
        end
        // Core write then read back
        bus.h_req = 0;
        bus.c_we = 1; bus.c_addr = 8'd5; bus.c_wdata = 8'h01;
        step();
        chk("wr_gnt", s_cg, 1);
        bus.c_we = 0;
        step();
        bus.c_req = 0;
        step();
        chk("rd_rvalid", s_crv, 1);
        chk("rd_data", s_crd, 8'h01);
        chk("rd_h_rvalid", s_hrv, 0);
        step();
        chk("rd_pulse", s_crv, 0);
        chk("rd_hold", s_crd, 8'h01);
        // Locked host burst holds off a waiting core
        bus.c_req = 1; bus.c_addr = 8'd3;
        bus.h_req = 1; bus.h_we = 0; bus.h_lock = 1; bus.h_addr = 8'd6;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("lock_h", s_hg, 1);
            chk("lock_c", s_cg, 0);
        end
        bus.h_req = 0; bus.h_lock = 0;
        step();
        chk("unlock_c", s_cg, 1);
        // Reset right after a host read grant
        bus.c_req = 0;
        bus.h_req = 1;
        step();
        chk("rr_hgnt", s_hg, 1);
        reset = 1;
        step();
        chk("rr_rvalid", s_hrv, 0);
        chk("rr_mem_en", s_me, 0);
        reset = 0;
        bus.c_req = 1;
        step();
        chk("rr_core", s_cg, 1);
`ifdef ARB_STATS_EN
        reset = 1;
        step();
        reset = 0;
        bus.h_req = 0;
        for (int i = 0; i < 3; i++) step();
        bus.c_req = 0;
        bus.h_req = 1;
        for (int i = 0; i < 2; i++) step();
        bus.h_req = 0;
        step();
        chk("cnt_c3", c_cnt, 3);
        chk("cnt_h2", h_cnt, 2);
        bus.c_req = 1;
        for (int i = 0; i < 65533; i++) step();
        bus.c_req = 0;
        step();
        chk("cnt_full", c_cnt, 16'hFFFF);
        bus.c_req = 1;
        step();
        bus.c_req = 0;
        step();
        chk("cnt_sat", c_cnt, 16'hFFFF);
`endif
        // Random traffic; requesters hold their request until granted
        for (int n = 0; n < 3000; n++) begin
            if (eg_c || !bus.c_req) begin
                bus.c_req = $urandom_range(0, 3) != 0;
                bus.c_we = 1'($urandom_range(0, 1));
                bus.c_addr = 8'($urandom_range(0, 7));
                bus.c_wdata = 8'($urandom);
            end
            if (eg_h || !bus.h_req) begin
                bus.h_req = $urandom_range(0, 3) != 0;
                bus.h_we = 1'($urandom_range(0, 1));
                bus.h_lock = $urandom_range(0, 2) == 0;
                bus.h_addr = 8'($urandom_range(0, 7));
                bus.h_wdata = 8'($urandom);
            end
            reset = $urandom_range(0, 60) == 0;
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 8, data-memory address width.
REQ-002 Parameter DW, default 8, data-memory data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 c_req, c_we  input  1 each  core access request and write enable.
REQ-006 c_addr, c_wdata  input  AW, DW  core address and write data.
REQ-007 c_gnt, c_rvalid  output  1 each  core grant and read-data valid.
REQ-008 c_rdata  output  DW  core read data.
REQ-009 h_req, h_we, h_lock  input  1 each  host request, write enable, burst lock.
REQ-010 h_addr, h_wdata  input  AW, DW  host address and write data.
REQ-011 h_gnt, h_rvalid  output  1 each  host grant and read-data valid.
REQ-012 h_rdata  output  DW  host read data.
REQ-013 mem_en, mem_we  output  1 each  memory access strobe and write enable.
REQ-014 mem_addr, mem_wdata  output  AW, DW  memory address and write data.
REQ-015 mem_rdata  input  DW  memory read data, valid one cycle after a read strobe.
REQ-016 c_cnt, h_cnt  output  16 each  grant counters (present only under ARB_STATS_EN).

Function
REQ-017 At most one of c_gnt and h_gnt SHALL be high in any cycle.
REQ-018 Grant SHALL be combinational, same cycle as req; a requester holds req/we/addr/wdata stable until it sees gnt.
REQ-019 mem_en SHALL equal c_gnt|h_gnt; mem_we/addr/wdata SHALL be muxed from the granted requester, else all zero.
REQ-020 Arbiter state: last-owner register (CORE, HOST) plus lock flag.
REQ-021 Single requester SHALL be granted immediately, regardless of last owner.
REQ-022 Both requesting, lock clear: grant the requester that is not last owner (round-robin).
REQ-023 Lock flag SHALL set at the clock edge when h_gnt=1 and h_lock=1; clear when h_lock=0 or h_req=0.
REQ-024 Lock flag set and h_req=1: host SHALL be granted even if last owner is HOST; core stalls.
REQ-025 Last owner SHALL update at the clock edge to the granted requester; unchanged in idle cycles.
REQ-026 Read grant (gnt=1, we=0) SHALL produce rvalid=1 for that requester exactly one cycle later, with rdata=mem_rdata.
REQ-027 rdata SHALL hold its last value when rvalid=0; rvalid is a one-cycle pulse per read grant.
REQ-028 Write grant SHALL produce no rvalid.
REQ-029 Back-to-back grants SHALL be sustained at one access per cycle; read in cycle N and access in N+1 are independent.

Reset
REQ-030 While reset=1: c_gnt, h_gnt, c_rvalid, h_rvalid, mem_en, mem_we=0; mem_addr, mem_wdata=0; lock flag clear.
REQ-031 After reset, last owner SHALL be HOST, so core wins the first contended cycle.
REQ-032 After reset, c_rdata, h_rdata SHALL be 0, and c_cnt, h_cnt SHALL be 0 when present.
REQ-033 Reset asserted in the cycle after a read grant SHALL suppress that rvalid.

Configuration
REQ-034 Macro ARB_STATS_EN defined: c_cnt/h_cnt ports exist and increment by 1 per grant of their requester.
REQ-035 Counters SHALL saturate at 16'hFFFF.
REQ-036 Macro ARB_STATS_EN undefined: c_cnt/h_cnt ports and counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-037 Post-reset, c_req=h_req=1, both reads: c_gnt cycle 1, h_gnt cycle 2, alternating thereafter.
REQ-038 Core write addr 5 data 8'h01, then core read addr 5: c_rvalid pulses one cycle after grant, c_rdata=8'h01, h_rvalid stays 0.
REQ-039 Host granted with h_lock=1 for 4 cycles while c_req=1: 4 consecutive h_gnt, c_gnt first high the cycle after h_lock drops.
REQ-040 Host read granted, reset=1 next cycle: h_rvalid stays 0, all outputs 0, next contention grants core.
REQ-041 ARB_STATS_EN: 3 core grants and 2 host grants give c_cnt=3, h_cnt=2; counter preloaded to 16'hFFFF stays 16'hFFFF after another grant.
REQ-042 Any random traffic: c_gnt&h_gnt never 1; mem_en==c_gnt|h_gnt every cycle.
